// File: rtl/axi_mem_port_arb_if.sv
// Bundle of the write-beat, read-beat and SRAM command/return signals shared
// by axi_mem_port_arb. "slave" is the arbiter's view, "master" the view of the
// requesters plus the RAM.
interface axi_mem_port_arb_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 64,
  parameter int STRB_WD = DATA_WD/8
);
  logic               WR_REQ;
  logic [ADDR_WD-1:0] WR_ADDR;
  logic [DATA_WD-1:0] WR_DATA;
  logic [STRB_WD-1:0] WR_STRB;
  logic               WR_LAST;
  logic               WR_GNT;
  logic               RD_REQ;
  logic [ADDR_WD-1:0] RD_ADDR;
  logic               RD_LAST;
  logic               RD_GNT;
  logic               RD_RVALID;
  logic [DATA_WD-1:0] RD_RDATA;
  logic               RD_RLAST;
  logic [ADDR_WD-1:0] RAM_ADDR;
  logic               RAM_WE;
  logic               RAM_RE;
  logic [DATA_WD-1:0] RAM_WDATA;
  logic [STRB_WD-1:0] RAM_WBE;
  logic [DATA_WD-1:0] RAM_RDATA;

  modport slave (
    input  WR_REQ, WR_ADDR, WR_DATA, WR_STRB, WR_LAST,
    input  RD_REQ, RD_ADDR, RD_LAST, RAM_RDATA,
    output WR_GNT, RD_GNT, RD_RVALID, RD_RDATA, RD_RLAST,
    output RAM_ADDR, RAM_WE, RAM_RE, RAM_WDATA, RAM_WBE
  );

  modport master (
    output WR_REQ, WR_ADDR, WR_DATA, WR_STRB, WR_LAST,
    output RD_REQ, RD_ADDR, RD_LAST, RAM_RDATA,
    input  WR_GNT, RD_GNT, RD_RVALID, RD_RDATA, RD_RLAST,
    input  RAM_ADDR, RAM_WE, RAM_RE, RAM_WDATA, RAM_WBE
  );
endinterface

// File: rtl/axi_mem_port_arb.sv
// Single-port SRAM arbiter between one write-beat and one read-beat requester.
// At most one beat is granted per cycle (combinational grant). MAX_HOLD bounds
// consecutive grants to one side under contention. Read data returns after
// RAM_RD_LAT cycles through a valid/last shift register, with no backpressure.
// Optional feature: define RAM_ARB_BURST_LOCK_EN to keep a burst contiguous
// (a grant with LAST=0 locks the arbiter to that side until its LAST beat).
module axi_mem_port_arb #(
  parameter int ADDR_WD    = 32,
  parameter int DATA_WD    = 64,
  parameter int STRB_WD    = DATA_WD/8,
  parameter int MAX_HOLD   = 4,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_mem_port_arb_if.slave    bus
);

  localparam int HW = $clog2(MAX_HOLD+1);

  typedef enum logic {SIDE_WR = 1'b0, SIDE_RD = 1'b1} side_e;

  side_e                 last;
  logic [HW-1:0]         hold_cnt;
  logic                  locked;
  logic                  wr_gnt, rd_gnt;
  logic                  hold_full;
  logic [RAM_RD_LAT-1:0] vld_pipe;
  logic [RAM_RD_LAT-1:0] last_pipe;

  assign hold_full = (hold_cnt == HW'(MAX_HOLD));

  // Grant selection: lock owner first, then sole requester, then `last` side
  // unless it has used up its hold budget. Nothing is granted during reset.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (ARESETn) begin
      if (locked) begin
        if (last == SIDE_WR) wr_gnt = bus.WR_REQ;
        else                 rd_gnt = bus.RD_REQ;
      end else if (bus.WR_REQ && bus.RD_REQ) begin
        if ((last == SIDE_WR) != hold_full) wr_gnt = 1'b1;
        else                                rd_gnt = 1'b1;
      end else begin
        wr_gnt = bus.WR_REQ;
        rd_gnt = bus.RD_REQ;
      end
    end
  end

  // Fairness state: extend the run on the same side, restart it on a switch.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      last     <= SIDE_WR;
      hold_cnt <= '0;
    end else if (wr_gnt) begin
      if (last == SIDE_WR) hold_cnt <= hold_full ? hold_cnt : hold_cnt + HW'(1);
      else begin
        last     <= SIDE_WR;
        hold_cnt <= HW'(1);
      end
    end else if (rd_gnt) begin
      if (last == SIDE_RD) hold_cnt <= hold_full ? hold_cnt : hold_cnt + HW'(1);
      else begin
        last     <= SIDE_RD;
        hold_cnt <= HW'(1);
      end
    end
  end

`ifdef RAM_ARB_BURST_LOCK_EN
  // Burst lock: held from a non-last beat until the owning side's last beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)    locked <= 1'b0;
    else if (wr_gnt) locked <= !bus.WR_LAST;
    else if (rd_gnt) locked <= !bus.RD_LAST;
  end
`else
  // Beats of different bursts may interleave; WR_LAST is not needed here.
  logic unused_wr_last;
  assign locked         = 1'b0;
  assign unused_wr_last = bus.WR_LAST;
`endif

  // Read return: track RAM_RE and RD_LAST for RAM_RD_LAT cycles.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= rd_gnt;
      last_pipe[0] <= rd_gnt & bus.RD_LAST;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign bus.WR_GNT    = wr_gnt;
  assign bus.RD_GNT    = rd_gnt;
  assign bus.RAM_WE    = wr_gnt;
  assign bus.RAM_RE    = rd_gnt;
  assign bus.RAM_ADDR  = wr_gnt ? bus.WR_ADDR : (rd_gnt ? bus.RD_ADDR : '0);
  assign bus.RAM_WDATA = bus.WR_DATA;
  assign bus.RAM_WBE   = wr_gnt ? bus.WR_STRB : '0;
  assign bus.RD_RVALID = vld_pipe[RAM_RD_LAT-1];
  assign bus.RD_RLAST  = last_pipe[RAM_RD_LAT-1];
  assign bus.RD_RDATA  = bus.RD_RVALID ? bus.RAM_RDATA : '0;

endmodule

// File: tb/tb_axi_mem_port_arb.sv
// Directed bench for axi_mem_port_arb: dut1 (RAM_RD_LAT=1) backed by a small
// byte-enable RAM model, dut2 (RAM_RD_LAT=2) for reset-with-reads-in-flight.
module tb_axi_mem_port_arb;
  logic ACLK = 1'b0;
  logic ARESETn;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 ACLK = ~ACLK;

  axi_mem_port_arb_if #(.ADDR_WD(32), .DATA_WD(64)) if1 ();
  axi_mem_port_arb_if #(.ADDR_WD(32), .DATA_WD(64)) if2 ();

  axi_mem_port_arb #(.ADDR_WD(32), .DATA_WD(64), .MAX_HOLD(4), .RAM_RD_LAT(1)) dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(if1.slave));
  axi_mem_port_arb #(.ADDR_WD(32), .DATA_WD(64), .MAX_HOLD(4), .RAM_RD_LAT(2)) dut2 (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(if2.slave));

  // RAM model for dut1: byte-masked write, read data one cycle after RAM_RE.
  logic [63:0] mem [logic [31:0]];
  always @(posedge ACLK) begin
    logic [63:0] w;
    if (if1.RAM_WE) begin
      w = mem.exists(if1.RAM_ADDR) ? mem[if1.RAM_ADDR] : 64'h0;
      for (int b = 0; b < 8; b++)
        if (if1.RAM_WBE[b]) w[b*8 +: 8] = if1.RAM_WDATA[b*8 +: 8];
      mem[if1.RAM_ADDR] = w;
    end
    if (if1.RAM_RE)
      if1.RAM_RDATA <= mem.exists(if1.RAM_ADDR) ? mem[if1.RAM_ADDR] : 64'h0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] exp_r;
    logic       ew;
    int         beat;

    ARESETn = 1'b0;
    if1.WR_REQ = 1'b1; if1.WR_ADDR = '0; if1.WR_DATA = '0; if1.WR_STRB = '0; if1.WR_LAST = 1'b1;
    if1.RD_REQ = 1'b1; if1.RD_ADDR = '0; if1.RD_LAST = 1'b1; if1.RAM_RDATA = '0;
    if2.WR_REQ = 1'b0; if2.WR_ADDR = 32'h500; if2.WR_DATA = '0; if2.WR_STRB = 8'hFF;
    if2.WR_LAST = 1'b1; if2.RD_REQ = 1'b0; if2.RD_ADDR = 32'h600; if2.RD_LAST = 1'b1;
    if2.RAM_RDATA = 64'h55;

    // reset state: grants forced low even with both requests up
    @(negedge ACLK);
    chk("rst_wr_gnt", if1.WR_GNT, 0);
    chk("rst_rd_gnt", if1.RD_GNT, 0);
    chk("rst_rvalid", if1.RD_RVALID, 0);
    chk("rst_ram_addr", if1.RAM_ADDR, 0);
    if1.WR_REQ = 1'b0; if1.RD_REQ = 1'b0;
    cyc();
    ARESETn = 1'b1;
    cyc();

    // test 1: four write beats, granted back to back
    for (int i = 0; i < 4; i++) begin
      if1.WR_REQ = 1'b1; if1.WR_ADDR = 32'(i*8); if1.WR_STRB = 8'hFF;
      if1.WR_DATA = 64'h1111_0000 + 64'(i);
      @(negedge ACLK);
      chk("t1_wr_gnt", if1.WR_GNT, 1);
      chk("t1_ram_we", if1.RAM_WE, 1);
      chk("t1_ram_addr", if1.RAM_ADDR, 64'(i*8));
      cyc();
    end

    // full write of the reference word at 0x40
    if1.WR_ADDR = 32'h40; if1.WR_DATA = 64'hDEADBEEF_CAFEF00D; if1.WR_STRB = 8'hFF;
    @(negedge ACLK);
    chk("t2_wr_gnt", if1.WR_GNT, 1);
    cyc();

    // test 6a: partial strobe write at 0x48, RAM_WBE follows WR_STRB
    if1.WR_ADDR = 32'h48; if1.WR_STRB = 8'h0F;
    @(negedge ACLK);
    chk("t6_wbe", if1.RAM_WBE, 64'h0F);
    chk("t6_wdata", if1.RAM_WDATA, 64'hDEADBEEF_CAFEF00D);
    cyc();
    if1.WR_REQ = 1'b0;

    // test 2: back-to-back reads of 0x40 and 0x48, one-cycle return
    if1.RD_REQ = 1'b1; if1.RD_ADDR = 32'h40; if1.RD_LAST = 1'b0;
    @(negedge ACLK);
    chk("t2_rd_gnt0", if1.RD_GNT, 1);
    chk("t2_ram_re", if1.RAM_RE, 1);
    chk("t2_ram_addr", if1.RAM_ADDR, 64'h40);
    chk("t2_wbe_rd", if1.RAM_WBE, 0);
    chk("t2_rvalid_early", if1.RD_RVALID, 0);
    cyc();
    if1.RD_ADDR = 32'h48; if1.RD_LAST = 1'b1;
    @(negedge ACLK);
    chk("t2_rd_gnt1", if1.RD_GNT, 1);
    chk("t2_rvalid0", if1.RD_RVALID, 1);
    chk("t2_rdata0", if1.RD_RDATA, 64'hDEADBEEF_CAFEF00D);
    chk("t2_rlast0", if1.RD_RLAST, 0);
    cyc();
    if1.RD_REQ = 1'b0;
    @(negedge ACLK);
    chk("t2_rvalid1", if1.RD_RVALID, 1);
    chk("t2_rdata1", if1.RD_RDATA, 64'h00000000_CAFEF00D);
    chk("t2_rlast1", if1.RD_RLAST, 1);
    cyc();
    @(negedge ACLK);
    chk("t2_rvalid_idle", if1.RD_RVALID, 0);
    chk("t2_rdata_idle", if1.RD_RDATA, 0);

    // test 3: continuous contention -> WWWWRRRRWWWW from reset
    ARESETn = 1'b0; cyc(); ARESETn = 1'b1;
    if1.WR_REQ = 1'b1; if1.WR_ADDR = 32'h100; if1.WR_STRB = 8'h0F; if1.WR_LAST = 1'b1;
    if1.RD_REQ = 1'b1; if1.RD_ADDR = 32'h200; if1.RD_LAST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ew = ((i / 4) % 2) == 0;
      @(negedge ACLK);
      chk($sformatf("t3_wr_gnt%0d", i), if1.WR_GNT, ew);
      chk($sformatf("t3_rd_gnt%0d", i), if1.RD_GNT, !ew);
      if (!ew) begin
        chk("t6_wbe_rd", if1.RAM_WBE, 0);
        chk("t3_ram_addr_rd", if1.RAM_ADDR, 64'h200);
      end
      cyc();
    end
    if1.WR_REQ = 1'b0; if1.RD_REQ = 1'b0;

    // test 4: 8-beat read burst, write request joins at beat 2
`ifdef RAM_ARB_BURST_LOCK_EN
    exp_r = 9'b0_1111_1111;
`else
    exp_r = 9'b1_0000_1111;
`endif
    ARESETn = 1'b0; cyc(); ARESETn = 1'b1;
    beat = 0;
    for (int c = 0; c < 9; c++) begin
      if1.WR_REQ  = (c >= 2);
      if1.WR_ADDR = 32'h400;
      if1.RD_REQ  = (beat < 8);
      if1.RD_ADDR = 32'h300 + 32'(beat*8);
      if1.RD_LAST = (beat == 7);
      @(negedge ACLK);
      chk($sformatf("t4_rd_gnt%0d", c), if1.RD_GNT, exp_r[c]);
      chk($sformatf("t4_wr_gnt%0d", c), if1.WR_GNT, !exp_r[c]);
      if (if1.RD_GNT) beat++;
      cyc();
    end
    if1.WR_REQ = 1'b0; if1.RD_REQ = 1'b0;

    // test 5: reset with read beats in flight on the two-cycle-latency port
    if2.RD_REQ = 1'b1;
    @(negedge ACLK);
    chk("t5_rd_gnt0", if2.RD_GNT, 1);
    cyc();
    @(negedge ACLK);
    chk("t5_rd_gnt1", if2.RD_GNT, 1);
    chk("t5_rvalid_lat", if2.RD_RVALID, 0);
    cyc();
    chk("t5_rvalid_pre", if2.RD_RVALID, 1);
    ARESETn = 1'b0;
    #1;
    chk("t5_rvalid_rst", if2.RD_RVALID, 0);
    chk("t5_rlast_rst", if2.RD_RLAST, 0);
    chk("t5_rd_gnt_rst", if2.RD_GNT, 0);
    cyc(); cyc();
    if2.RD_REQ = 1'b0;
    ARESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("t5_no_return", if2.RD_RVALID, 0);
      cyc();
    end
    if2.WR_REQ = 1'b1; if2.RD_REQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk($sformatf("t5_wr_gnt%0d", i), if2.WR_GNT, i < 4);
      chk($sformatf("t5_rd_gnt%0d", i), if2.RD_GNT, i == 4);
      cyc();
    end
    if2.WR_REQ = 1'b0; if2.RD_REQ = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
